muldiv_unit: RTL and testbench

Multi-cycle RV32M execution unit, parametrised in XLEN. It decodes ALUOp/Funct7/Funct3 for M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It executes them with a latency-configurable multiplier and an iterative radix-2 divider. Sits beside the main ALU in EX and stalls the pipeline through a valid/ready handshake.

---
 rtl/riscv_md_pkg.sv | 28 ++
 rtl/md_divider.sv | 73 +++++++
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_md_pkg.sv
// Shared definitions for the RV32M multiply/divide execution unit:
// funct3 op codes, decode constants and the unit's FSM state encoding.
package riscv_md_pkg;

  // funct3 encodings of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

  // Unit sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle.
// A start pulse loads the operands; XLEN cycles later done rises and the
// quotient/remainder stay valid until the next start, flush or reset.
// A zero divisor is never started (handled upstream).
module md_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] dvs_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Trial subtraction of the divisor from the partial remainder shifted
  // left by one with the next dividend bit; the top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_reg, quo_reg[XLEN-1]};
    diff    = shifted - {1'b0, dvs_reg};
  end

  // Load on start, then shift one quotient bit into quo_reg per cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      quo_reg  <= '0;
      rem_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      quo_reg  <= dividend;
      rem_reg  <= '0;
      dvs_reg  <= divisor;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      if (!diff[XLEN]) begin
        rem_reg <= diff[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg <= shifted[XLEN-1:0];
        quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
      end
      cnt_reg <= cnt_reg + CW'(1);
      if (cnt_reg == CW'(XLEN - 1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit beside the main ALU. Accepts one op through a
// valid/ready handshake, runs MUL* with a fixed configurable latency and
// DIV*/REM* on an iterative divider (with one-cycle special cases), then
// holds the result until the consumer takes it.
module muldiv_unit
  import riscv_md_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic            busy
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_reg, state_next;
  md_op_e            op_reg, op_next;
  logic [XLEN-1:0]   a_reg, a_next;
  logic [XLEN-1:0]   b_reg, b_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic              illegal_reg, illegal_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // request-side decode (valid only in the accept cycle)
  logic              is_m;
  logic              in_signed;
  logic              in_fast;
  logic [XLEN-1:0]   in_mag_a;
  logic [XLEN-1:0]   in_mag_b;

  // multiplier datapath
  logic              a_sgn;
  logic              b_sgn;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_result;

  // divider datapath
  logic              div_start;
  logic              div_done;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;
  logic              op_signed;
  logic              op_is_rem;
  logic              div_fast;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   fast_result;
  logic [XLEN-1:0]   fix_result;

  // Decode the presented op and prepare divider operand magnitudes so the
  // first iteration can happen on the edge right after accept.
  always_comb begin
    is_m      = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
    in_signed = ~Funct3[0];
    in_fast   = (op_b == '0) || (in_signed && (op_a == MIN_INT) && (op_b == '1));
    in_mag_a  = (in_signed && op_a[XLEN-1]) ? -op_a : op_a;
    in_mag_b  = (in_signed && op_b[XLEN-1]) ? -op_b : op_b;
  end

  // Full 2*XLEN product of the latched operands with per-op signedness
  always_comb begin
    a_sgn      = (op_reg == OP_MULH) || (op_reg == OP_MULHSU);
    b_sgn      = (op_reg == OP_MULH);
    a_ext      = {{XLEN{a_sgn & a_reg[XLEN-1]}}, a_reg};
    b_ext      = {{XLEN{b_sgn & b_reg[XLEN-1]}}, b_reg};
    product    = a_ext * b_ext;
    mul_result = (op_reg == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // Divide special cases and sign fix-up of the unsigned core's results
  always_comb begin
    op_signed   = ~op_reg[0];
    op_is_rem   = op_reg[1];
    div_fast    = (b_reg == '0) ||
                  (op_signed && (a_reg == MIN_INT) && (b_reg == '1));
    // zero divisor: quotient all ones, remainder = dividend;
    // MIN_INT / -1 overflow: quotient = dividend, remainder = 0
    if (b_reg == '0) begin
      fast_result = op_is_rem ? a_reg : '1;
    end else begin
      fast_result = op_is_rem ? '0 : a_reg;
    end
    a_neg = op_signed & a_reg[XLEN-1];
    b_neg = op_signed & b_reg[XLEN-1];
    if (op_is_rem) begin
      fix_result = a_neg ? -div_rem : div_rem;
    end else begin
      fix_result = (a_neg ^ b_neg) ? -div_quo : div_quo;
    end
  end

  // Next-state and datapath load decisions; flush discards everything
  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
    cnt_next     = cnt_reg;
    div_start    = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next      = md_op_e'(Funct3);
            a_next       = op_a;
            b_next       = op_b;
            illegal_next = ~is_m;
            cnt_next     = '0;
            if (is_m && Funct3[2]) begin
              state_next = DIV;
              div_start  = ~in_fast;
            end else begin
              // non-M ops ride the MUL path and complete after one cycle
              state_next = MUL;
            end
          end
        end
        MUL: begin
          if (illegal_reg || (cnt_reg == CNT_W'(MUL_LATENCY - 1))) begin
            state_next  = DONE;
            result_next = illegal_reg ? '0 : mul_result;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DIV: begin
          if (div_fast) begin
            state_next  = DONE;
            result_next = fast_result;
          end else if (div_done) begin
            state_next  = DONE;
            result_next = fix_result;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latched operands, result and latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= OP_MUL;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
      cnt_reg     <= cnt_next;
    end
  end

  md_divider #(
    .XLEN(XLEN)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .start    (div_start),
    .dividend (in_mag_a),
    .divisor  (in_mag_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic
// reference model of the RV32M operations and their completion latency.
module tb_muldiv_unit;

  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN       (XLEN),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (ALUOp),
    .Funct7   (Funct7),
    .Funct3   (Funct3),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .illegal  (illegal),
    .busy     (busy)
  );

  // Reference model: {illegal, result} from the instruction semantics
  function automatic logic [32:0] ref_model(logic [1:0] aluop, logic [6:0] f7,
                                            logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          si, sj;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    si = $signed(a);
    sj = $signed(b);
    if (aluop != 2'b10 || f7 != 7'b0000001) return {1'b1, 32'h0};
    case (f3)
      3'd0: begin p = sa * sb; return {1'b0, p[31:0]}; end
      3'd1: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'd2: begin p = sa * ub; return {1'b0, p[63:32]}; end
      3'd3: begin p = ua * ub; return {1'b0, p[63:32]}; end
      3'd4: begin
        if (b == 0) return {1'b0, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, a};
        return {1'b0, 32'(si / sj)};
      end
      3'd5: begin
        if (b == 0) return {1'b0, 32'hFFFFFFFF};
        return {1'b0, a / b};
      end
      3'd6: begin
        if (b == 0) return {1'b0, a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0};
        return {1'b0, 32'(si % sj)};
      end
      default: begin
        if (b == 0) return {1'b0, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  // Expected cycles from accept edge to out_valid
  function automatic int exp_lat(logic [1:0] aluop, logic [6:0] f7, logic [2:0] f3,
                                 logic [31:0] a, logic [31:0] b);
    if (aluop != 2'b10 || f7 != 7'b0000001) return 1;
    if (!f3[2]) return MUL_LATENCY;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present one op (unit must be idle), then wait for out_valid; leaves
  // the unit in DONE with out_ready low.
  task automatic issue(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ill, output int lat,
                       output bit ready_low);
    ALUOp = aluop; Funct7 = f7; Funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALUOp = 2'($urandom); Funct7 = 7'($urandom); Funct3 = 3'($urandom);
    op_a = $urandom; op_b = $urandom;
    lat = 0;
    ready_low = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    ill = illegal;
    $display("op aluop=%b f7=%b f3=%0d a=%h b=%h -> result=%h illegal=%0b latency=%0d",
             aluop, f7, f3, a, b, res, ill, lat);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    // reset must win over a presented op
    reset = 1'b1; in_valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0;
    op_a = 32'd3; op_b = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h expected 0", result); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b expected 0", illegal); end
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [2:0]  d_f3 [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] d_a  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_b  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_r  [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [2:0]  f3;
    logic [31:0] a, b, res, er;
    logic        ill, ei;
    int          lat;
    bit          rl;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin f3 = d_f3[i]; a = d_a[i]; b = d_b[i]; end
      else begin f3 = 3'($urandom_range(0, 3)); a = rand_opnd(); b = rand_opnd(); end
      issue(2'b10, 7'b0000001, f3, a, b, res, ill, lat, rl);
      {ei, er} = ref_model(2'b10, 7'b0000001, f3, a, b);
      if (i < 4 && er !== d_r[i]) $display("note: model disagrees with directed table at %0d", i);
      vectors++; if (res !== er) begin miscompares++; $display("FAIL mul_result f3=%0d a=%h b=%h got %h expected %h", f3, a, b, res, er); end
      vectors++; if (ill !== ei) begin miscompares++; $display("FAIL mul_illegal f3=%0d got %b expected %b", f3, ill, ei); end
      vectors++; if (lat != exp_lat(2'b10, 7'b0000001, f3, a, b)) begin miscompares++; $display("FAIL mul_latency f3=%0d got %0d expected %0d", f3, lat, exp_lat(2'b10, 7'b0000001, f3, a, b)); end
      ack();
    end
  endtask

  task automatic test_div();
    logic [2:0]  d_f3 [3] = '{3'd4, 3'd6, 3'd5};
    logic [31:0] d_a  [3] = '{-32'd20, -32'd20, 32'hFFFFFFFF};
    logic [31:0] d_b  [3] = '{32'd3, 32'd3, 32'd2};
    logic [2:0]  f3;
    logic [31:0] a, b, res, er;
    logic        ill, ei;
    int          lat;
    bit          rl;
    for (int i = 0; i < 19; i++) begin
      if (i < 3) begin f3 = d_f3[i]; a = d_a[i]; b = d_b[i]; end
      else begin f3 = 3'($urandom_range(4, 7)); a = rand_opnd(); b = rand_opnd(); end
      issue(2'b10, 7'b0000001, f3, a, b, res, ill, lat, rl);
      {ei, er} = ref_model(2'b10, 7'b0000001, f3, a, b);
      vectors++; if (res !== er) begin miscompares++; $display("FAIL div_result f3=%0d a=%h b=%h got %h expected %h", f3, a, b, res, er); end
      vectors++; if (lat != exp_lat(2'b10, 7'b0000001, f3, a, b)) begin miscompares++; $display("FAIL div_latency f3=%0d a=%h b=%h got %0d expected %0d", f3, a, b, lat, exp_lat(2'b10, 7'b0000001, f3, a, b)); end
      vectors++; if (!rl) begin miscompares++; $display("FAIL div_in_ready_low got 1 while busy expected 0"); end
      vectors++; if (ill !== ei) begin miscompares++; $display("FAIL div_illegal got %b expected %b", ill, ei); end
      ack();
    end
  endtask

  task automatic test_fast_paths();
    logic [2:0]  d_f3 [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a  [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [2:0]  f3;
    logic [31:0] a, b, res, er;
    logic        ill, ei;
    int          lat;
    bit          rl;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin f3 = d_f3[i]; a = d_a[i]; b = d_b[i]; end
      else begin f3 = 3'($urandom_range(4, 7)); a = $urandom; b = 32'h0; end
      issue(2'b10, 7'b0000001, f3, a, b, res, ill, lat, rl);
      {ei, er} = ref_model(2'b10, 7'b0000001, f3, a, b);
      vectors++; if (res !== er) begin miscompares++; $display("FAIL fast_result f3=%0d a=%h b=%h got %h expected %h", f3, a, b, res, er); end
      vectors++; if (lat != 1) begin miscompares++; $display("FAIL fast_latency f3=%0d got %0d expected 1", f3, lat); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    logic        ill;
    int          lat;
    bit          rl;
    issue(2'b10, 7'b0000001, 3'd0, 32'd7, 32'hFFFFFFFD, res, ill, lat, rl);
    vectors++; if (res !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL bp_result got %h expected ffffffeb", res); end
    repeat (5) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || result !== 32'hFFFFFFEB || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold out_valid=%b result=%h in_ready=%b expected 1/ffffffeb/0", out_valid, result, in_ready);
      end
    end
    // consumer takes the result while a non-M op is already presented
    ALUOp = 2'b10; Funct7 = 7'b0100000; Funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_illegal out_valid=%b illegal=%b result=%h expected 1/1/0", out_valid, illegal, result);
    end
    $display("op aluop=10 f7=0100000 f3=0 -> result=%h illegal=%0b", result, illegal);
    ack();
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd4; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic        ill;
    int          lat;
    bit          rl;
    bit          seen;
    start_div(32'd100, 32'd7);
    // flush with a new op presented: both the in-flight op and this one die
    flush = 1'b1; in_valid = 1'b1; Funct3 = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_idle in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL flush_no_valid out_valid rose got 1 expected 0"); end
    issue(2'b10, 7'b0000001, 3'd4, 32'd9, 32'd3, res, ill, lat, rl);
    vectors++; if (res !== 32'd3) begin miscompares++; $display("FAIL flush_next_div got %h expected 00000003", res); end
    vectors++; if (lat != XLEN + 1) begin miscompares++; $display("FAIL flush_next_latency got %0d expected %0d", lat, XLEN + 1); end
    ack();
    start_div($urandom, 32'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (out_valid !== 1'b0 || result !== 32'h0) begin miscompares++; $display("FAIL midop_reset out_valid=%b result=%h expected 0/0", out_valid, result); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midop_reset_ready got %b expected 1", in_ready); end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL reset_no_valid out_valid rose got 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  aluop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b, res, er;
    logic        ill, ei;
    int          lat;
    bit          rl;
    for (int i = 0; i < 40; i++) begin
      aluop = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10;
      f7    = ($urandom_range(0, 7) == 0) ? 7'b0100000 : 7'b0000001;
      f3    = 3'($urandom);
      a     = rand_opnd();
      b     = rand_opnd();
      issue(aluop, f7, f3, a, b, res, ill, lat, rl);
      {ei, er} = ref_model(aluop, f7, f3, a, b);
      vectors++; if (res !== er) begin miscompares++; $display("FAIL b2b_result aluop=%b f7=%b f3=%0d a=%h b=%h got %h expected %h", aluop, f7, f3, a, b, res, er); end
      vectors++; if (ill !== ei) begin miscompares++; $display("FAIL b2b_illegal got %b expected %b", ill, ei); end
      vectors++; if (lat != exp_lat(aluop, f7, f3, a, b)) begin miscompares++; $display("FAIL b2b_latency got %0d expected %0d", lat, exp_lat(aluop, f7, f3, a, b)); end
      ack();
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_release out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'd0; op_a = '0; op_b = '0;
    test_reset();
    test_mul();
    test_div();
    test_fast_paths();
    test_backpressure();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
